// File: rtl/vram_port_arbiter_if.sv
// Bus-side register path into the VRAM port arbiter.
// The master holds a request stable until it sees the one-cycle ack.
interface vram_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single VRAM port shared by glyph fetch (absolute priority) and the bus path.
// Define VRAM_RMW_EN to turn partial-strobe writes into read-modify-write.
module vram_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1200,
    parameter int RD_LAT = 1
) (
    input  logic                pixel_clk,
    input  logic                arstn,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_rvalid,
    output logic [DATA_W-1:0]   vid_rdata,
    vram_port_arbiter_if.slave  bus,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    localparam int          STRB_W  = DATA_W / 8;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        TAG_NONE, TAG_VID, TAG_VZ, TAG_BUS, TAG_RMW
    } tag_t;

    typedef enum logic [2:0] {
        IDLE, BUS_RD_WAIT, ACK
`ifdef VRAM_RMW_EN
        , RMW_RD, RMW_WAIT, RMW_WR
`endif
    } state_t;

    state_t            state_q, state_d;
    tag_t              tag_q [RD_LAT];
    tag_t              tag_in;
    tag_t              tag_head;
    logic              vid_oor, bus_oor;
    logic              done, done_err;
    logic [DATA_W-1:0] done_rdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    assign vid_oor  = 32'(vid_addr) >= DEPTH_U;
    assign bus_oor  = 32'(bus.bus_addr) >= DEPTH_U;
    assign tag_head = tag_q[RD_LAT-1];

    assign bus.bus_ack   = (state_q == ACK);
    assign bus.bus_rdata = rdata_q;
    assign bus.bus_err   = err_q;

`ifdef VRAM_RMW_EN
    logic              partial;
    logic [DATA_W-1:0] merge_q, merge_d;

    assign partial = !(&bus.bus_wstrb) && (|bus.bus_wstrb);

    // Overlay the strobed bytes onto the word read back from RAM.
    always_comb begin
        merge_d = ram_rdata;
        for (int i = 0; i < STRB_W; i++) begin
            if (bus.bus_wstrb[i]) begin
                merge_d[8*i +: 8] = bus.bus_wdata[8*i +: 8];
            end
        end
    end

    // Hold the merged word until the write-back slot is free.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            merge_q <= '0;
        end else if (state_q == RMW_WAIT && tag_head == TAG_RMW) begin
            merge_q <= merge_d;
        end
    end
`endif

    // Port mux and bus FSM: video always wins the port, the bus waits.
    always_comb begin
        state_d    = state_q;
        tag_in     = TAG_NONE;
        ram_en     = 1'b0;
        ram_we     = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;

        if (vid_req) begin
            tag_in   = vid_oor ? TAG_VZ : TAG_VID;
            ram_en   = !vid_oor;
            ram_addr = vid_addr;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.bus_req) begin
                    if (bus_oor) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                        state_d  = ACK;
                    end else if (bus.bus_we && bus.bus_wstrb == '0) begin
                        done    = 1'b1;
                        state_d = ACK;
`ifdef VRAM_RMW_EN
                    end else if (bus.bus_we && partial) begin
                        state_d = RMW_RD;
`endif
                    end else if (!vid_req) begin
                        ram_en   = 1'b1;
                        ram_addr = bus.bus_addr;
                        if (bus.bus_we) begin
                            ram_we    = bus.bus_wstrb;
                            ram_wdata = bus.bus_wdata;
                            done      = 1'b1;
                            state_d   = ACK;
                        end else begin
                            tag_in  = TAG_BUS;
                            state_d = BUS_RD_WAIT;
                        end
                    end
                end
            end
            BUS_RD_WAIT: begin
                if (tag_head == TAG_BUS) begin
                    done       = 1'b1;
                    done_rdata = ram_rdata;
                    state_d    = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
`ifdef VRAM_RMW_EN
            RMW_RD: begin
                if (!vid_req) begin
                    ram_en   = 1'b1;
                    ram_addr = bus.bus_addr;
                    tag_in   = TAG_RMW;
                    state_d  = RMW_WAIT;
                end
            end
            RMW_WAIT: begin
                if (tag_head == TAG_RMW) begin
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                if (!vid_req) begin
                    ram_en    = 1'b1;
                    ram_we    = '1;
                    ram_addr  = bus.bus_addr;
                    ram_wdata = merge_q;
                    done      = 1'b1;
                    state_d   = ACK;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!arstn) begin
            ram_en    = 1'b0;
            ram_we    = '0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    // Bus FSM state register.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner tags ride alongside the RAM read latency.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Video return: fixed latency, zero data for out-of-range fetches.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
        end else begin
            vid_rvalid <= (tag_head == TAG_VID) || (tag_head == TAG_VZ);
            if (tag_head == TAG_VID) begin
                vid_rdata <= ram_rdata;
            end else if (tag_head == TAG_VZ) begin
                vid_rdata <= '0;
            end
        end
    end

    // Bus completion data, held until the next ack.
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (done) begin
            rdata_q <= done_rdata;
            err_q   <= done_err;
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter (RD_LAT=1, DEPTH=1200).
// Behavioural 1-cycle RAM plus a shadow memory that predicts read data.
module tb_vram_port_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int NWORDS = 1200;

`ifdef VRAM_RMW_EN
    localparam int PW_LAT = -1;
`else
    localparam int PW_LAT = 1;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk;
        int          cyc;
    } exp_t;

    logic              pixel_clk = 1'b0;
    logic              arstn;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    vram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    vram_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(NWORDS), .RD_LAT(1)
    ) dut (
        .pixel_clk (pixel_clk),
        .arstn     (arstn),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rvalid(vid_rvalid),
        .vid_rdata (vid_rdata),
        .bus       (bif.slave),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 pixel_clk = ~pixel_clk;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [NWORDS];
    logic [31:0] ref_mem [2048];
    exp_t        bq[$];
    exp_t        vq[$];
    exp_t        be, ve;
    logic        cur_we;
    logic [10:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // RAM model with one cycle of read latency.
    always @(posedge pixel_clk) begin
        if (ram_en && 32'(ram_addr) < 32'd1200) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    // Output monitor: pops scoreboard entries on every response pulse.
    always @(negedge pixel_clk) begin
        if (bif.bus_ack === 1'b1) begin
            if (bq.size() == 0) begin
                check("bus_spurious_ack", 64'd1, 64'd0);
            end else begin
                be = bq.pop_front();
                check("bus_err", 64'(bif.bus_err), 64'(be.err));
                if (be.chk) check("bus_rdata", 64'(bif.bus_rdata), 64'(be.data));
                if (be.cyc >= 0) check("bus_ack_cycle", 64'(cyc), 64'(be.cyc));
            end
        end
        if (vid_rvalid === 1'b1) begin
            if (vq.size() == 0) begin
                check("vid_spurious_rvalid", 64'd1, 64'd0);
            end else begin
                ve = vq.pop_front();
                check("vid_rdata", 64'(vid_rdata), 64'(ve.data));
                check("vid_rvalid_cycle", 64'(cyc), 64'(ve.cyc));
            end
        end
        if (ram_en === 1'b1) begin
            check("ram_addr_range", 64'(32'(ram_addr) < 32'd1200), 64'd1);
`ifdef VRAM_RMW_EN
            if (ram_we != 4'h0) check("ram_we_full", 64'(ram_we), 64'hF);
`endif
        end
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic bus_start(input logic we, input logic [10:0] a,
                             input logic [31:0] wd, input logic [3:0] st,
                             input int lat, input logic push);
        logic oor;
        oor = 32'(a) >= 32'd1200;
        bif.bus_req   = 1'b1;
        bif.bus_we    = we;
        bif.bus_addr  = a;
        bif.bus_wdata = wd;
        bif.bus_wstrb = st;
        cur_we = we; cur_addr = a; cur_wdata = wd; cur_wstrb = st;
        if (push) begin
            bq.push_back('{data: oor ? 32'h0 : ref_mem[a], err: oor,
                           chk: !we, cyc: (lat < 0) ? -1 : cyc + lat});
        end
    endtask

    task automatic bus_wait();
        int n;
        n = 0;
        forever begin
            @(negedge pixel_clk);
            if (bif.bus_ack === 1'b1) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            check("bus_ack_timeout", 64'd0, 64'd1);
            if (bq.size() != 0) void'(bq.pop_back());
        end else if (cur_we && 32'(cur_addr) < 32'd1200) begin
            ref_mem[cur_addr] = merge(ref_mem[cur_addr], cur_wdata, cur_wstrb);
        end
        tick();
        bif.bus_req = 1'b0;
    endtask

    task automatic bus_op(input logic we, input logic [10:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input int lat);
        bus_start(we, a, wd, st, lat, 1'b1);
        bus_wait();
    endtask

    task automatic vid_start(input logic [10:0] a);
        vid_req  = 1'b1;
        vid_addr = a;
        vq.push_back('{data: (32'(a) < 32'd1200) ? ref_mem[a] : 32'h0,
                       err: 1'b0, chk: 1'b1, cyc: cyc + 2});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        arstn    = 1'b0;
        vid_req  = 1'b0;
        vid_addr = '0;
        bif.bus_req   = 1'b1;
        bif.bus_we    = 1'b1;
        bif.bus_addr  = 11'd3;
        bif.bus_wdata = 32'hCAFEF00D;
        bif.bus_wstrb = 4'hF;

        // Reset held with a bus request pending.
        repeat (4) begin
            @(negedge pixel_clk);
            check("rst_ram_en", 64'(ram_en), 64'd0);
            check("rst_ram_we", 64'(ram_we), 64'd0);
            check("rst_bus_ack", 64'(bif.bus_ack), 64'd0);
            check("rst_vid_rvalid", 64'(vid_rvalid), 64'd0);
            check("rst_bus_rdata", 64'(bif.bus_rdata), 64'd0);
        end
        tick();
        bif.bus_req = 1'b0;
        tick();
        arstn = 1'b1;
        tick();

        // Full write then read back.
        bus_op(1'b1, 11'd5, 32'hDEADBEEF, 4'hF, 1);
        bus_op(1'b0, 11'd5, 32'h0, 4'h0, 2);

        // Video and bus contend in the same cycle.
        bus_op(1'b1, 11'd10, 32'hA5A50010, 4'hF, 1);
        bus_op(1'b1, 11'd20, 32'h5A5A0020, 4'hF, 1);
        vid_start(11'd10);
        bus_start(1'b0, 11'd20, 32'h0, 4'h0, 3, 1'b1);
        tick();
        vid_req = 1'b0;
        bus_wait();
        vid_start(11'd1200);
        tick();
        vid_start(11'd5);
        tick();
        vid_req = 1'b0;

        // Partial writes.
        bus_op(1'b1, 11'd7, 32'h11223344, 4'hF, 1);
        bus_op(1'b1, 11'd7, 32'h0000AB00, 4'b0010, PW_LAT);
        bus_op(1'b0, 11'd7, 32'h0, 4'h0, 2);
        bus_op(1'b1, 11'd7, 32'hEE0000DD, 4'b1001, PW_LAT);
        bus_op(1'b1, 11'd7, 32'hFFFFFFFF, 4'b0000, 1);
        bus_op(1'b0, 11'd7, 32'h0, 4'h0, 2);

        // Range boundary.
        bus_op(1'b1, 11'd1200, 32'h12345678, 4'hF, 1);
        bus_op(1'b0, 11'd1200, 32'h0, 4'h0, 1);
        bus_op(1'b1, 11'd2047, 32'h87654321, 4'h3, 1);
        bus_op(1'b1, 11'd1199, 32'h0BADCAFE, 4'hF, 1);
        bus_op(1'b0, 11'd1199, 32'h0, 4'h0, 2);

        // Starvation: write issues only in the first free cycle.
        for (int i = 0; i < 100; i++) begin
            vid_start((i % 2 == 0) ? 11'd10 : 11'd20);
            if (i == 0) bus_start(1'b1, 11'd30, 32'h30303030, 4'hF, 101, 1'b1);
            tick();
        end
        vid_req = 1'b0;
        bus_wait();
        bus_op(1'b0, 11'd30, 32'h0, 4'h0, 2);

        // Reset while a starved write is pending: no ack, no write.
        for (int i = 0; i < 20; i++) begin
            vid_start(11'd5);
            if (i == 0) bus_start(1'b1, 11'd31, 32'h31313131, 4'hF, 0, 1'b0);
            tick();
        end
        vid_req = 1'b0;
        arstn = 1'b0;
        bif.bus_req = 1'b0;
        tick();
        tick();
        check("vid_inflight_drop", 64'(vq.size()), 64'd1);
        vq.delete();
        arstn = 1'b1;
        tick();
        bus_op(1'b0, 11'd31, 32'h0, 4'h0, 2);

`ifdef VRAM_RMW_EN
        // Reset in RMW_WAIT: write abandoned, FSM back to IDLE.
        bus_op(1'b1, 11'd40, 32'h40404040, 4'hF, 1);
        bus_start(1'b1, 11'd40, 32'h000000FF, 4'b0001, 0, 1'b0);
        tick();
        tick();
        arstn = 1'b0;
        bif.bus_req = 1'b0;
        tick();
        tick();
        arstn = 1'b1;
        tick();
        bus_op(1'b0, 11'd40, 32'h0, 4'h0, 2);
`endif

        repeat (4) tick();
        check("bus_queue_empty", 64'(bq.size()), 64'd0);
        check("vid_queue_empty", 64'(vq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
